fft_bfly_sched: RTL and testbench



---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_addr_gen.sv | 37 +++
 rtl/fft_bfly_sched.sv | 180 ++++++++++++++++++
 tb/tb_fft_bfly_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 DIF FFT butterfly sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fft_pkg;

  localparam int ADDR_WIDTH   = 4;
  localparam int STAGES       = ADDR_WIDTH;
  localparam int TW_WIDTH     = ADDR_WIDTH - 1;
  // Idle issue slots between stages so the last write of a stage lands
  // before the first read of the next one.
  localparam int GAP_CYCLES   = 2;
  // Cycles spent after the last issue so the issue, twiddle and write
  // registers drain before done is raised.
  localparam int FLUSH_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FLUSH
  } state_t;

  // One butterfly travelling down the issue -> butterfly -> write-back pipe.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [TW_WIDTH-1:0]   tw_idx;
  } pipe_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly) to in-place DIF read addresses and twiddle index.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fft_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int TW_WIDTH   = ADDR_WIDTH - 1
) (
  input  logic [ADDR_WIDTH-1:0] stage,
  input  logic [ADDR_WIDTH-2:0] bfly,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [TW_WIDTH-1:0]   tw2_idx
);

  localparam int BW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] HALF = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [BW-1:0]         ONES = '1;

  logic [ADDR_WIDTH-1:0] span;
  logic [BW-1:0]         mask;
  logic [BW-1:0]         pos;
  logic [BW-1:0]         grp_bits;

  // span is a power of two, so grp*2*span+pos reduces to inserting a zero
  // bit at position log2(span) of the butterfly number: the low bits are
  // pos, the high bits (grp*span) are shifted up by one.
  always_comb begin
    span     = HALF >> stage;
    mask     = ONES >> stage;          // span - 1
    pos      = bfly & mask;
    grp_bits = bfly & ~mask;           // grp * span
    addr_a   = {grp_bits, 1'b0} | {1'b0, pos};
    addr_b   = addr_a + span;          // span bit of addr_a is clear, no carry
    tw2_idx  = pos << stage;
  end

endmodule

// File: rtl/fft_bfly_sched.sv
// Issues every butterfly of every FFT stage: read addresses, twiddles, writes.
// Latency: first read 1 cycle after start, writes 2 cycles after their read.
// Backpressure: none; start is ignored while a transform is in progress.
module fft_bfly_sched #(
  parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH,
  parameter int TW_WIDTH   = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  ff_en,
  output logic [TW_WIDTH-1:0]   tw1_idx,
  output logic [TW_WIDTH-1:0]   tw2_idx,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr_a,
  output logic [ADDR_WIDTH-1:0] wr_addr_b,
  output logic [ADDR_WIDTH-1:0] stage
);

  import fft_pkg::*;

  localparam int BW = ADDR_WIDTH - 1;
  localparam logic [BW-1:0]         LAST_BFLY  = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_STAGE = ADDR_WIDTH'(ADDR_WIDTH - 1);
  localparam logic [1:0]            GAP_LAST   = 2'(GAP_CYCLES - 1);
  localparam logic [1:0]            FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] stage_cnt, stage_d;
  logic [BW-1:0]         bfly_cnt, bfly_d;
  logic [1:0]            cnt, cnt_d;
  logic                  issue, busy_d, done_d;

  logic [ADDR_WIDTH-1:0] ag_addr_a, ag_addr_b;
  logic [TW_WIDTH-1:0]   ag_tw;

  pipe_t iss, s1, s2;

  // The write stage carries a twiddle field it never needs.
  logic unused_s2_tw;
  assign unused_s2_tw = ^s2.tw_idx;

  fft_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TW_WIDTH   (TW_WIDTH)
  ) u_addr_gen (
    .stage   (stage_cnt),
    .bfly    (bfly_cnt),
    .addr_a  (ag_addr_a),
    .addr_b  (ag_addr_b),
    .tw2_idx (ag_tw)
  );

  // Next-state, counter updates and registered-output precursors.
  always_comb begin
    state_d = state;
    stage_d = stage_cnt;
    bfly_d  = bfly_cnt;
    cnt_d   = cnt;
    done_d  = 1'b0;
    issue   = (state == RUN);
    busy_d  = (state != IDLE);
    case (state)
      IDLE: begin
        // done high means this is the completion cycle; start is dropped.
        if (start && !done) begin
          state_d = RUN;
          stage_d = '0;
          bfly_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bfly_cnt == LAST_BFLY) begin
          bfly_d  = '0;
          cnt_d   = '0;
          state_d = (stage_cnt == LAST_STAGE) ? FLUSH : GAP;
        end else begin
          bfly_d = bfly_cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = RUN;
          stage_d = stage_cnt + 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          // Final write is on the outputs now; done follows it, and a start
          // present at this point chains straight into the next transform.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          stage_d = '0;
          state_d = start ? RUN : IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and stage/butterfly/gap counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stage_cnt <= '0;
      bfly_cnt  <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      stage_cnt <= stage_d;
      bfly_cnt  <= bfly_d;
      cnt       <= cnt_d;
    end
  end

  // Registered status outputs; stage lines up with the issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      stage <= '0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      stage <= stage_cnt;
    end
  end

  // Issue -> butterfly -> write-back pipe; payloads only move with a valid
  // butterfly so twiddles and addresses change only in their strobe cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss <= '0;
      s1  <= '0;
      s2  <= '0;
    end else begin
      iss.valid <= issue;
      if (issue) begin
        iss.addr_a <= ag_addr_a;
        iss.addr_b <= ag_addr_b;
        iss.tw_idx <= ag_tw;
      end
      s1.valid <= iss.valid;
      if (iss.valid) begin
        s1.addr_a <= iss.addr_a;
        s1.addr_b <= iss.addr_b;
        s1.tw_idx <= iss.tw_idx;
      end
      s2.valid <= s1.valid;
      if (s1.valid) begin
        s2.addr_a <= s1.addr_a;
        s2.addr_b <= s1.addr_b;
        s2.tw_idx <= s1.tw_idx;
      end
    end
  end

  assign rd_en     = iss.valid;
  assign rd_addr_a = iss.addr_a;
  assign rd_addr_b = iss.addr_b;
  assign ff_en     = s1.valid;
  assign tw1_idx   = '0;              // sum path is never rotated
  assign tw2_idx   = s1.tw_idx;
  assign wr_en     = s2.valid;
  assign wr_addr_a = s2.addr_a;
  assign wr_addr_b = s2.addr_b;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched at N=16: timing, addresses, start/rst cases.
// Latency: cycle c is the interval after rising edge c; start is seen at edge 0.
// Backpressure: not applicable.
module tb_fft_bfly_sched;

  localparam int AW = 4;
  localparam int TW = 3;
  localparam int NC = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, rd_en, ff_en, wr_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [TW-1:0] tw1_idx, tw2_idx;

  fft_bfly_sched #(.ADDR_WIDTH(AW), .TW_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .ff_en     (ff_en),
    .tw1_idx   (tw1_idx),
    .tw2_idx   (tw2_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic          rec_rd[NC], rec_ff[NC], rec_wr[NC], rec_busy[NC], rec_done[NC];
  logic [AW-1:0] rec_ra[NC], rec_rb[NC], rec_wa[NC], rec_wb[NC], rec_stg[NC];
  logic [TW-1:0] rec_tw1[NC], rec_tw2[NC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 1 when cycle c lies in [lo+10s, hi+10s] for some stage s of N=16.
  function automatic logic in_win(input int c, input int lo, input int hi);
    for (int s = 0; s < 4; s++)
      if (c >= lo + 10*s && c <= hi + 10*s) return 1'b1;
    return 1'b0;
  endfunction

  // mode 0: single start pulse; 1: extra pulses seen at edges 5 and 20;
  // 2: start held high. rst_cyc >= 0 asserts rst so it is seen at edge rst_cyc+1.
  task automatic capture(input int mode, input int rst_cyc);
    start = 1'b1;
    for (int c = 0; c < NC; c++) begin
      tick();
      rec_rd[c]   = rd_en;     rec_ff[c]  = ff_en;     rec_wr[c]  = wr_en;
      rec_busy[c] = busy;      rec_done[c] = done;
      rec_ra[c]   = rd_addr_a; rec_rb[c]  = rd_addr_b;
      rec_wa[c]   = wr_addr_a; rec_wb[c]  = wr_addr_b;
      rec_tw1[c]  = tw1_idx;   rec_tw2[c] = tw2_idx;   rec_stg[c] = stage;
      start = (mode == 2) || (mode == 1 && (c == 4 || c == 19));
      rst   = (c == rst_cyc);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int nrd = 0, nff = 0, nwr = 0;
    int erd = 0, eff = 0, ewr = 0, ebusy = 0, edone = 0, ealign = 0, etw = 0, etw1 = 0;
    logic [15:0] seen;
    for (int c = 0; c < NC; c++) begin
      nrd += int'(rec_rd[c]); nff += int'(rec_ff[c]); nwr += int'(rec_wr[c]);
      if (rec_rd[c] !== in_win(c, 1, 8))  erd++;
      if (rec_ff[c] !== in_win(c, 2, 9))  eff++;
      if (rec_wr[c] !== in_win(c, 3, 10)) ewr++;
      if (rec_busy[c] !== ((c >= 1 && c <= 40) ? 1'b1 : 1'b0)) ebusy++;
      if (rec_done[c] !== ((c == 41) ? 1'b1 : 1'b0)) edone++;
      if (c >= 2 && rec_wr[c] === 1'b1 &&
          (rec_wa[c] !== rec_ra[c-2] || rec_wb[c] !== rec_rb[c-2])) ealign++;
      if (c >= 1 && rec_tw2[c] !== rec_tw2[c-1] && rec_ff[c] !== 1'b1) etw++;
      if (rec_tw1[c] !== 3'd0) etw1++;
    end
    check({tag, "_rd_count"}, nrd, 32);
    check({tag, "_ff_count"}, nff, 32);
    check({tag, "_wr_count"}, nwr, 32);
    check({tag, "_rd_window_errs"}, erd, 0);
    check({tag, "_ff_window_errs"}, eff, 0);
    check({tag, "_wr_window_errs"}, ewr, 0);
    check({tag, "_busy_window_errs"}, ebusy, 0);
    check({tag, "_done_pulse_errs"}, edone, 0);
    check({tag, "_wr_vs_rd_align_errs"}, ealign, 0);
    check({tag, "_tw2_change_outside_ff"}, etw, 0);
    check({tag, "_tw1_nonzero"}, etw1, 0);
    // stage 0 bfly 0 issues cycle 1
    check({tag, "_s0b0_a"}, rec_ra[1], 0);
    check({tag, "_s0b0_b"}, rec_rb[1], 8);
    check({tag, "_s0b0_tw2"}, rec_tw2[2], 0);
    // stage 1 bfly 5 issues cycle 16
    check({tag, "_s1b5_a"}, rec_ra[16], 9);
    check({tag, "_s1b5_b"}, rec_rb[16], 13);
    check({tag, "_s1b5_tw2"}, rec_tw2[17], 2);
    check({tag, "_s1b5_stage"}, rec_stg[16], 1);
    // stage 2 bfly 3 issues cycle 24
    check({tag, "_s2b3_a"}, rec_ra[24], 5);
    check({tag, "_s2b3_b"}, rec_rb[24], 7);
    check({tag, "_s2b3_tw2"}, rec_tw2[25], 4);
    // stage 3 bfly 7 issues cycle 38
    check({tag, "_s3b7_a"}, rec_ra[38], 14);
    check({tag, "_s3b7_b"}, rec_rb[38], 15);
    check({tag, "_s3b7_tw2"}, rec_tw2[39], 0);
    check({tag, "_s3b7_stage"}, rec_stg[38], 3);
    for (int s = 0; s < 4; s++) begin
      seen = '0;
      for (int c = 3 + 10*s; c <= 10 + 10*s; c++) begin
        seen[rec_wa[c]] = 1'b1;
        seen[rec_wb[c]] = 1'b1;
      end
      check($sformatf("%s_stage%0d_write_cover", tag, s), seen, 16'hFFFF);
    end
  endtask

  initial begin
    int late;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_ff_en", ff_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr_b", rd_addr_b, 0);
    check("rst_wr_addr_b", wr_addr_b, 0);
    check("rst_tw2", tw2_idx, 0);
    check("rst_stage", stage, 0);
    rst = 1'b0;
    tick();

    // Single transform.
    capture(0, -1);
    check_run("single");
    repeat (3) tick();

    // Start pulses while busy are ignored.
    capture(1, -1);
    check_run("pulsed");
    repeat (3) tick();

    // Start held high: back-to-back transforms.
    capture(2, -1);
    check("held_done_41", rec_done[41], 1);
    check("held_busy_41", rec_busy[41], 0);
    check("held_rd_41", rec_rd[41], 0);
    check("held_rd_42", rec_rd[42], 1);
    check("held_busy_42", rec_busy[42], 1);
    check("held_ra_42", rec_ra[42], 0);
    check("held_rb_42", rec_rb[42], 8);
    check("held_stage_42", rec_stg[42], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Reset seen at edge 18 with writes still in flight.
    capture(0, 17);
    check("rst17_wr_before", rec_wr[17], 1);
    check("rst17_rd", rec_rd[18], 0);
    check("rst17_ff", rec_ff[18], 0);
    check("rst17_wr", rec_wr[18], 0);
    check("rst17_busy", rec_busy[18], 0);
    check("rst17_done", rec_done[18], 0);
    check("rst17_rd_addr_a", rec_ra[18], 0);
    check("rst17_wr_addr_a", rec_wa[18], 0);
    check("rst17_tw2", rec_tw2[18], 0);
    check("rst17_stage", rec_stg[18], 0);
    late = 0;
    for (int c = 19; c < NC; c++)
      late += int'(rec_rd[c]) + int'(rec_ff[c]) + int'(rec_wr[c]) +
              int'(rec_done[c]) + int'(rec_busy[c]);
    check("rst17_activity_after", late, 0);

    // A fresh start after the abandoned transform runs normally.
    capture(0, -1);
    check_run("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
